inverse_substitution_serial: RTL and testbench

Column-serial inverse of the ASCON substitution layer: applies the inverse 5-bit S-box to all 64 columns of a 320-bit state, `COLS_PER_CYCLE` columns per clock, under a start/busy/done handshake. It sits beside the combinational forward substitution layer in the permutation datapath. It serves the inverse-permutation path used by the reference model and debug, and it undoes one forward substitution bit-exactly.

---
 rtl/inverse_substitution_serial_pkg.sv | 31 +++
 rtl/inverse_substitution_serial_inv_sbox.sv | 21 ++
 rtl/inverse_substitution_serial.sv | 122 ++++++++++++
 tb/tb_inverse_substitution_serial.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/inverse_substitution_serial_pkg.sv
// Shared ASCON types and S-box tables for the permutation datapath.
package ascon_pack;

    typedef logic [4:0][63:0] type_state;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } type_inv_sub_fsm;

    localparam logic [4:0] INV_SBOX [32] = '{
        5'd20, 5'd26, 5'd7,  5'd13, 5'd0,  5'd9,  5'd14, 5'd18,
        5'd10, 5'd6,  5'd29, 5'd1,  5'd25, 5'd21, 5'd19, 5'd30,
        5'd24, 5'd22, 5'd11, 5'd17, 5'd3,  5'd5,  5'd28, 5'd31,
        5'd23, 5'd27, 5'd4,  5'd8,  5'd15, 5'd12, 5'd16, 5'd2
    };

    localparam logic [4:0] FWD_SBOX [32] = '{
        5'd4,  5'd11, 5'd31, 5'd20, 5'd26, 5'd21, 5'd9,  5'd2,
        5'd27, 5'd5,  5'd8,  5'd18, 5'd29, 5'd3,  5'd6,  5'd28,
        5'd30, 5'd19, 5'd7,  5'd14, 5'd0,  5'd13, 5'd17, 5'd24,
        5'd16, 5'd12, 5'd1,  5'd25, 5'd22, 5'd10, 5'd15, 5'd23
    };

    // Row 0 is the MSB of a column word, matching the forward layer.
    function automatic logic [4:0] get_column(input type_state s, input logic [5:0] c);
        return {s[0][c], s[1][c], s[2][c], s[3][c], s[4][c]};
    endfunction

endpackage

// File: rtl/inverse_substitution_serial_inv_sbox.sv
// Single-column 5-bit inverse S-box; the forward sbox is only built when
// INV_SUB_SELFCHECK_EN is defined, since only the self-check uses it.
module inv_sbox
    import ascon_pack::*;
(
    input  logic [4:0] x,
    output logic [4:0] y
);
    assign y = INV_SBOX[x];
endmodule

`ifdef INV_SUB_SELFCHECK_EN
module sbox
    import ascon_pack::*;
(
    input  logic [4:0] x,
    output logic [4:0] y
);
    assign y = FWD_SBOX[x];
endmodule
`endif

// File: rtl/inverse_substitution_serial.sv
// Column-serial inverse ASCON substitution layer, COLS_PER_CYCLE columns per clock.
// Optional INV_SUB_SELFCHECK_EN re-applies the forward S-box and flags mismatches on err_o.
//
// state | meaning
// IDLE  | waiting for start_i, state_o holds the last result
// RUN   | rewriting one chunk of columns per cycle in place
// DONE  | one-cycle result strobe, start_i accepted with no bubble
module inverse_substitution_serial
    import ascon_pack::*;
#(
    parameter int COLS_PER_CYCLE = 8
)
(
    input  logic      clock_i,
    input  logic      reset_i,
    input  logic      start_i,
    input  type_state state_i,
    output logic      busy_o,
    output logic      done_o,
    output type_state state_o,
    output logic      err_o
);
    localparam int N = COLS_PER_CYCLE;
    // N = 64 gives a step of 0, which is correct for the single-chunk case.
    localparam logic [5:0] STEP     = 6'(N % 64);
    localparam logic [5:0] LAST_CNT = 6'(64 - N);

    if (!(N == 1 || N == 2 || N == 4 || N == 8 || N == 16 || N == 32 || N == 64)) begin : g_bad_cols
        $error("COLS_PER_CYCLE must be one of 1, 2, 4, 8, 16, 32, 64");
    end

    type_inv_sub_fsm fsm_q;
    logic [5:0]      cnt_q;
    type_state       work_q;
    logic            accept;
    logic            last;

    logic [5:0] lane_col [N];
    logic [4:0] lane_in  [N];
    logic [4:0] lane_out [N];

    for (genvar g = 0; g < N; g++) begin : g_lane
        assign lane_col[g] = cnt_q + 6'(g);
        assign lane_in[g]  = get_column(work_q, lane_col[g]);
        inv_sbox u_inv_sbox (
            .x (lane_in[g]),
            .y (lane_out[g])
        );
    end

    assign accept = start_i && (fsm_q != RUN);
    assign last   = (cnt_q == LAST_CNT);

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            fsm_q  <= IDLE;
            cnt_q  <= '0;
            work_q <= '0;
        end else begin
            case (fsm_q)
                IDLE, DONE: begin
                    if (accept) begin
                        fsm_q  <= RUN;
                        cnt_q  <= '0;
                        work_q <= state_i;
                    end else begin
                        fsm_q <= IDLE;
                    end
                end
                RUN: begin
                    for (int g = 0; g < N; g++) begin
                        for (int r = 0; r < 5; r++) begin
                            work_q[r][lane_col[g]] <= lane_out[g][4-r];
                        end
                    end
                    cnt_q <= cnt_q + STEP;
                    if (last) begin
                        fsm_q <= DONE;
                    end
                end
                default: fsm_q <= IDLE;
            endcase
        end
    end

    assign busy_o  = (fsm_q == RUN);
    assign done_o  = (fsm_q == DONE);
    assign state_o = work_q;

`ifdef INV_SUB_SELFCHECK_EN
    type_state  shadow_q;
    logic       err_q;
    logic [4:0] lane_fwd [N];
    logic [N-1:0] lane_bad;

    // Each freshly inverted chunk must map back onto the captured original.
    for (genvar g = 0; g < N; g++) begin : g_check
        sbox u_sbox (
            .x (lane_out[g]),
            .y (lane_fwd[g])
        );
        assign lane_bad[g] = (lane_fwd[g] != get_column(shadow_q, lane_col[g]));
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            shadow_q <= '0;
            err_q    <= 1'b0;
        end else if (accept) begin
            shadow_q <= state_i;
            err_q    <= 1'b0;
        end else if (fsm_q == RUN && |lane_bad) begin
            err_q <= 1'b1;
        end
    end

    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_inverse_substitution_serial.sv
// Bench for inverse_substitution_serial: three widths checked every cycle against a layer-level model.
module tb_inverse_substitution_serial;
    import ascon_pack::*;

    localparam int NK = 3;

    logic      clock = 1'b0;
    logic      reset;
    logic      start [NK];
    type_state din   [NK];
    type_state dout  [NK];
    logic      busy  [NK];
    logic      done  [NK];
    logic      err   [NK];

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    int cols  [NK] = '{1, 8, 64};
    int inv_t [32] = '{20, 26, 7, 13, 0, 9, 14, 18, 10, 6, 29, 1, 25, 21, 19, 30,
                       24, 22, 11, 17, 3, 5, 28, 31, 23, 27, 4, 8, 15, 12, 16, 2};
    int fwd_t [32];

    always #5 clock = ~clock;
    always @(posedge clock) cyc++;

    inverse_substitution_serial #(.COLS_PER_CYCLE(1)) u_n1 (
        .clock_i(clock), .reset_i(reset), .start_i(start[0]), .state_i(din[0]),
        .busy_o(busy[0]), .done_o(done[0]), .state_o(dout[0]), .err_o(err[0]));
    inverse_substitution_serial #(.COLS_PER_CYCLE(8)) u_n8 (
        .clock_i(clock), .reset_i(reset), .start_i(start[1]), .state_i(din[1]),
        .busy_o(busy[1]), .done_o(done[1]), .state_o(dout[1]), .err_o(err[1]));
    inverse_substitution_serial #(.COLS_PER_CYCLE(64)) u_n64 (
        .clock_i(clock), .reset_i(reset), .start_i(start[2]), .state_i(din[2]),
        .busy_o(busy[2]), .done_o(done[2]), .state_o(dout[2]), .err_o(err[2]));

    task automatic chk(input string name, input logic [319:0] act, input logic [319:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Whole-layer substitution, column by column, row 0 as MSB.
    function automatic type_state layer(input type_state s, input bit inverse);
        type_state  o;
        logic [4:0] w;
        int         v;
        o = '0;
        for (int c = 0; c < 64; c++) begin
            w = {s[0][c], s[1][c], s[2][c], s[3][c], s[4][c]};
            v = inverse ? inv_t[w] : fwd_t[w];
            for (int r = 0; r < 5; r++) o[r][c] = v[4-r];
        end
        return o;
    endfunction

    function automatic type_state rand_state();
        type_state s;
        for (int r = 0; r < 5; r++) s[r] = {$urandom(), $urandom()};
        return s;
    endfunction

    // Reference: remaining busy cycles per instance, result captured at acceptance.
    int        m_rem     [NK];
    bit        m_done    [NK];
    bit        m_valid   [NK];
    bit        m_err     [NK];
    bit        ign_state [NK];
    bit        ign_err   [NK];
    type_state m_out     [NK];
    bit        mon_en = 1'b0;

    always @(posedge clock) begin
        for (int k = 0; k < NK; k++) begin
            if (reset) begin
                m_rem[k] = 0; m_done[k] = 0; m_out[k] = '0; m_valid[k] = 1; m_err[k] = 0;
                ign_state[k] = 0; ign_err[k] = 0;
            end else if (m_rem[k] == 0 && start[k]) begin
                m_rem[k] = 64 / cols[k]; m_done[k] = 0; m_valid[k] = 0; m_err[k] = 0;
                m_out[k] = layer(din[k], 1'b1);
                ign_state[k] = 0; ign_err[k] = 0;
            end else if (m_rem[k] > 0) begin
                m_rem[k]--;
                m_done[k]  = (m_rem[k] == 0);
                m_valid[k] = (m_rem[k] == 0);
            end else begin
                m_done[k] = 0;
            end
        end
    end

    always @(negedge clock) begin
        if (mon_en) begin
            for (int k = 0; k < NK; k++) begin
                chk($sformatf("busy_n%0d", cols[k]), busy[k], m_rem[k] > 0);
                chk($sformatf("done_n%0d", cols[k]), done[k], m_done[k]);
                if (m_valid[k] && !ign_state[k]) chk($sformatf("state_n%0d", cols[k]), dout[k], m_out[k]);
                if (!ign_err[k]) chk($sformatf("err_n%0d", cols[k]), err[k], m_err[k]);
            end
        end
    end

    task automatic run_job(input int k, input type_state s, input bit toggle,
                           output type_state res, output int lat);
        int n;
        n = 0;
        while (m_rem[k] != 0 && n < 200) begin @(posedge clock); #1; n++; end
        din[k] = s; start[k] = 1'b1; lat = cyc;
        n = 0;
        do begin
            @(posedge clock); #1;
            if (m_rem[k] > 0 && toggle) begin
                start[k] = 1'($urandom_range(0, 1));
                din[k]   = rand_state();
            end else begin
                start[k] = 1'b0;
            end
            @(negedge clock); n++;
        end while (!done[k] && n < 200);
        chk($sformatf("done_seen_n%0d", cols[k]), done[k], 1'b1);
        lat = cyc - lat;
        res = dout[k];
    endtask

    task automatic rand_jobs(input int k, input int count);
        type_state orig, res;
        int lat;
        for (int j = 0; j < count; j++) begin
            orig = rand_state();
            run_job(k, layer(orig, 1'b0), 1'b1, res, lat);
            chk($sformatf("roundtrip_n%0d", cols[k]), res, orig);
            chk($sformatf("latency_n%0d", cols[k]), lat, 64 / cols[k] + 1);
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        type_state zero_img, row2, orig, res;
        int lat, prev, pulses, n, n_done;

        for (int x = 0; x < 32; x++) fwd_t[inv_t[x]] = x;
        reset = 1'b1;
        for (int k = 0; k < NK; k++) begin start[k] = 1'b0; din[k] = '0; end
        zero_img = '0; zero_img[0] = '1; zero_img[2] = '1;
        row2 = '0; row2[2] = '1;

        repeat (3) @(posedge clock);
        #1; reset = 1'b0; mon_en = 1'b1;
        @(negedge clock);

        chk("model_inv_zero", layer('0, 1'b1), zero_img);
        chk("model_fwd_zero", layer('0, 1'b0), row2);
        for (int k = 0; k < NK; k++) begin
            chk("reset_busy", busy[k], 1'b0);
            chk("reset_done", done[k], 1'b0);
            chk("reset_state", dout[k], '0);
            chk("reset_err", err[k], 1'b0);
        end

        run_job(1, '0, 1'b0, res, lat);
        chk("zero_result_n8", res, zero_img);
        chk("zero_latency_n8", lat, 9);
        run_job(1, row2, 1'b0, res, lat);
        chk("row2_result_n8", res, '0);
        run_job(0, '0, 1'b0, res, lat);
        chk("zero_result_n1", res, zero_img);
        chk("zero_latency_n1", lat, 65);
        run_job(2, '0, 1'b0, res, lat);
        chk("zero_result_n64", res, zero_img);
        chk("zero_latency_n64", lat, 2);

        fork
            rand_jobs(0, 300);
            rand_jobs(1, 1000);
            rand_jobs(2, 1000);
        join

        // Start held high: a new job every 9 cycles with no bubble.
        @(negedge clock);
        orig = rand_state();
        din[1] = layer(orig, 1'b0); start[1] = 1'b1;
        prev = -1; pulses = 0; n = 0;
        while (pulses < 6 && n < 100) begin
            @(negedge clock); n++;
            if (done[1]) begin
                if (prev >= 0) chk("b2b_interval", cyc - prev, 9);
                chk("b2b_result", dout[1], orig);
                prev = cyc; pulses++;
            end
        end
        chk("b2b_pulses", pulses, 6);
        start[1] = 1'b0;

        // Abort in the fourth RUN cycle.
        @(negedge clock);
        din[1] = rand_state(); start[1] = 1'b1;
        @(posedge clock); #1; start[1] = 1'b0;
        repeat (3) @(posedge clock);
        #1; reset = 1'b1;
        @(posedge clock); #1; reset = 1'b0;
        @(negedge clock);
        chk("abort_busy", busy[1], 1'b0);
        chk("abort_done", done[1], 1'b0);
        chk("abort_state", dout[1], '0);
        n_done = 0;
        repeat (12) begin @(negedge clock); if (done[1]) n_done++; end
        chk("abort_no_done", n_done, 0);
        orig = rand_state();
        run_job(1, layer(orig, 1'b0), 1'b0, res, lat);
        chk("after_abort_result", res, orig);
        chk("after_abort_latency", lat, 9);

`ifdef INV_SUB_SELFCHECK_EN
        @(negedge clock);
        orig = rand_state();
        din[1] = layer(orig, 1'b0); start[1] = 1'b1;
        @(posedge clock); #1; start[1] = 1'b0;
        ign_state[1] = 1'b1; ign_err[1] = 1'b1;
        @(negedge clock);
        u_n8.work_q[0][63] = ~u_n8.work_q[0][63];
        n = 0;
        while (!done[1] && n < 50) begin @(negedge clock); n++; end
        chk("selfcheck_done", done[1], 1'b1);
        chk("selfcheck_err", err[1], 1'b1);
        run_job(1, layer(orig, 1'b0), 1'b0, res, lat);
        chk("selfcheck_clear", err[1], 1'b0);
        chk("selfcheck_result", res, orig);
`endif

        @(negedge clock);
        mon_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
